// File: rtl/systolic_sched.sv
// ---------------------------------------------------------------------------
// systolic_sched
// Sequencer for the systolic datapath. Runs a job of num_tiles weight tiles
// back-to-back. The first tile's weights are preloaded. Each later tile's
// weights are loaded into the shadow buffer while the current tile's inputs
// stream. After the last tile the output pipeline drains, then done pulses.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   start          in   job start pulse, accepted only in IDLE
//   abort          in   synchronous abort, overrides every other event
//   num_tiles      in   tile count, captured on start
//   w_done         in   datapath weight counter reached SYS_ROWS-1
//   if_done        in   datapath input counter reached A_ROWS-1
//   w_buffer_read  out  pop weight buffer
//   if_buffer_read out  pop input buffer
//   clr_w          out  hold/clear datapath weight counter
//   clr_if         out  hold/clear datapath input counter
//   switch         out  one-cycle swap of shadow/active weights
//   of_valid       out  output row valid (if_buffer_read delayed LAT cycles)
//   busy           out  sequencer not idle
//   done           out  one-cycle job completion pulse
//   tile_idx       out  index of the tile being streamed
// ---------------------------------------------------------------------------
module systolic_sched #(
   parameter int unsigned SYS_ROWS = 16,
   parameter int unsigned SYS_COLS = 16,
   parameter int unsigned A_ROWS   = 64,
   parameter int unsigned TILE_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [TILE_W-1:0] num_tiles,
   input  logic              w_done,
   input  logic              if_done,
   output logic              w_buffer_read,
   output logic              if_buffer_read,
   output logic              clr_w,
   output logic              clr_if,
   output logic              switch,
   output logic              of_valid,
   output logic              busy,
   output logic              done,
   output logic [TILE_W-1:0] tile_idx
);

   localparam int unsigned LAT    = SYS_ROWS + SYS_COLS - 1;
   localparam int unsigned DCNT_W = $clog2(LAT + 1);

   // The next tile's weights must finish loading before the current stream ends.
   if (A_ROWS < SYS_ROWS) begin : g_cfg_check
      $error("systolic_sched: A_ROWS must be >= SYS_ROWS");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PRELOAD = 3'd1,
      S_SWAP    = 3'd2,
      S_STREAM  = 3'd3,
      S_DRAIN   = 3'd4
   } state_t;

   state_t            state, state_d;
   logic [TILE_W-1:0] tiles_left, tiles_left_d;
   logic [TILE_W-1:0] tile_idx_d;
   logic [DCNT_W-1:0] drain_cnt, drain_cnt_d;
   logic              w_ready, w_ready_d;
   logic              done_d;
   logic              w_rd_d, if_rd_d, switch_d, busy_d;
   logic [LAT-1:0]    of_pipe;

   // Next-state logic; outputs are decoded from the next state so they register
   // alongside it.
   always_comb begin
      state_d      = state;
      tiles_left_d = tiles_left;
      tile_idx_d   = tile_idx;
      drain_cnt_d  = drain_cnt;
      w_ready_d    = w_ready;
      done_d       = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               if (num_tiles != '0) begin
                  tiles_left_d = num_tiles;
                  tile_idx_d   = '0;
                  w_ready_d    = 1'b0;
                  state_d      = S_PRELOAD;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_PRELOAD: begin
            if (w_done) state_d = S_SWAP;
         end
         S_SWAP: begin
            // tiles_left counts tiles still to be swapped in after this one.
            tiles_left_d = tiles_left - TILE_W'(1);
            w_ready_d    = 1'b0;
            state_d      = S_STREAM;
         end
         S_STREAM: begin
            if (w_done && (tiles_left != '0)) w_ready_d = 1'b1;
            if (if_done) begin
               if (tiles_left != '0) begin
                  tile_idx_d = tile_idx + TILE_W'(1);
                  state_d    = S_SWAP;
               end else begin
                  drain_cnt_d = '0;
                  state_d     = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (drain_cnt == DCNT_W'(LAT - 1)) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               drain_cnt_d = drain_cnt + DCNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d    = S_IDLE;
         done_d     = 1'b0;
         tile_idx_d = tile_idx;
      end

      // Weight reads: whole of PRELOAD, and the head of STREAM while a further
      // tile remains and its weights are not yet in.
      w_rd_d   = (state_d == S_PRELOAD) ||
                 ((state_d == S_STREAM) && (tiles_left_d != '0) && !w_ready_d);
      if_rd_d  = (state_d == S_STREAM);
      switch_d = (state_d == S_SWAP);
      busy_d   = (state_d != S_IDLE);
   end

   // State, bookkeeping and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= S_IDLE;
         tiles_left     <= '0;
         tile_idx       <= '0;
         drain_cnt      <= '0;
         w_ready        <= 1'b0;
         done           <= 1'b0;
         w_buffer_read  <= 1'b0;
         if_buffer_read <= 1'b0;
         clr_w          <= 1'b1;
         clr_if         <= 1'b1;
         switch         <= 1'b0;
         busy           <= 1'b0;
         of_pipe        <= '0;
      end else begin
         state          <= state_d;
         tiles_left     <= tiles_left_d;
         tile_idx       <= tile_idx_d;
         drain_cnt      <= drain_cnt_d;
         w_ready        <= w_ready_d;
         done           <= done_d;
         w_buffer_read  <= w_rd_d;
         if_buffer_read <= if_rd_d;
         clr_w          <= !w_rd_d;
         clr_if         <= !if_rd_d;
         switch         <= switch_d;
         busy           <= busy_d;
         // Output-valid latency line; abort drops rows still in flight.
         if (abort) of_pipe <= '0;
         else       of_pipe <= (of_pipe << 1) | LAT'(if_buffer_read);
      end
   end

   assign of_valid = of_pipe[LAT-1];

endmodule

// File: tb/tb_systolic_sched.sv
// ---------------------------------------------------------------------------
// tb_systolic_sched
// Self-checking bench for systolic_sched (SYS_ROWS=SYS_COLS=4, A_ROWS=8).
// Expected outputs per cycle come from the job timeline: preload, then per
// tile one swap cycle plus A_ROWS stream cycles, then LAT drain cycles.
// w_done/if_done are driven from that same timeline, with spurious pulses in
// phases where they must be ignored.
// ---------------------------------------------------------------------------
module tb_systolic_sched;

   localparam int SR  = 4;
   localparam int SC  = 4;
   localparam int A   = 8;
   localparam int TW  = 8;
   localparam int LAT = SR + SC - 1;

   localparam int PH_PRE = 0;
   localparam int PH_SWP = 1;
   localparam int PH_STR = 2;
   localparam int PH_DRN = 3;
   localparam int PH_IDL = 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic          abort;
   logic [TW-1:0] num_tiles;
   logic          w_done;
   logic          if_done;
   logic          w_buffer_read;
   logic          if_buffer_read;
   logic          clr_w;
   logic          clr_if;
   logic          sw;
   logic          of_valid;
   logic          busy;
   logic          done;
   logic [TW-1:0] tile_idx;

   int n_checks = 0;
   int n_err    = 0;

   systolic_sched #(
      .SYS_ROWS(SR), .SYS_COLS(SC), .A_ROWS(A), .TILE_W(TW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .num_tiles(num_tiles),
      .w_done(w_done), .if_done(if_done),
      .w_buffer_read(w_buffer_read), .if_buffer_read(if_buffer_read),
      .clr_w(clr_w), .clr_if(clr_if), .switch(sw), .of_valid(of_valid),
      .busy(busy), .done(done), .tile_idx(tile_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Cycle index of the done pulse, counted from the first cycle after start.
   function automatic int t_end(input int n);
      return SR + n * (A + 1) + LAT;
   endfunction

   // Phase of cycle c of an n-tile job; k = tile, j = offset within phase.
   function automatic int phase_of(input int n, input int c, output int k, output int j);
      int p;
      k = 0;
      j = c;
      if (c < 0)  return PH_IDL;
      if (c < SR) return PH_PRE;
      p = c - SR;
      if (p < n * (A + 1)) begin
         k = p / (A + 1);
         j = (p % (A + 1)) - 1;
         return (j < 0) ? PH_SWP : PH_STR;
      end
      k = n - 1;
      j = p - n * (A + 1);
      return (j < LAT) ? PH_DRN : PH_IDL;
   endfunction

   // Compare every output with the timeline value for cycle c (c<0: idle).
   task automatic check_cycle(input string tag, input int n, input int c);
      int   k, j, k2, j2, ph;
      logic e_wrd, e_ifrd, e_sw, e_ofv, e_busy, e_done;
      ph     = phase_of(n, c, k, j);
      e_ifrd = (ph == PH_STR);
      e_wrd  = (ph == PH_PRE) || (e_ifrd && (k < n - 1) && (j < SR));
      e_sw   = (ph == PH_SWP);
      e_ofv  = (phase_of(n, c - LAT, k2, j2) == PH_STR);
      e_busy = (ph != PH_IDL);
      e_done = (c == t_end(n));
      chk({tag, ".w_read"},  32'(w_buffer_read),  32'(e_wrd));
      chk({tag, ".if_read"}, 32'(if_buffer_read), 32'(e_ifrd));
      chk({tag, ".clr_w"},   32'(clr_w),          32'(!e_wrd));
      chk({tag, ".clr_if"},  32'(clr_if),         32'(!e_ifrd));
      chk({tag, ".switch"},  32'(sw),             32'(e_sw));
      chk({tag, ".of_valid"},32'(of_valid),       32'(e_ofv));
      chk({tag, ".busy"},    32'(busy),           32'(e_busy));
      chk({tag, ".done"},    32'(done),           32'(e_done));
      if (e_busy) chk({tag, ".tile_idx"}, 32'(tile_idx), 32'(k));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".w_read"},   32'(w_buffer_read),  32'd0);
      chk({tag, ".if_read"},  32'(if_buffer_read), 32'd0);
      chk({tag, ".clr_w"},    32'(clr_w),          32'd1);
      chk({tag, ".clr_if"},   32'(clr_if),         32'd1);
      chk({tag, ".switch"},   32'(sw),             32'd0);
      chk({tag, ".of_valid"}, 32'(of_valid),       32'd0);
      chk({tag, ".busy"},     32'(busy),           32'd0);
      chk({tag, ".done"},     32'(done),           32'd0);
      chk({tag, ".tile_idx"}, 32'(tile_idx),       32'd0);
   endtask

   task automatic quiet_inputs();
      start   = 1'b0;
      abort   = 1'b0;
      w_done  = 1'b0;
      if_done = 1'b0;
   endtask

   // Idle cycles with stray done pulses and occasional aborts, all to be ignored.
   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check_cycle("idle", 1, -1);
         start     = 1'b0;
         abort     = ($urandom_range(0, 7) == 0);
         w_done    = ($urandom_range(0, 2) == 0);
         if_done   = ($urandom_range(0, 2) == 0);
         num_tiles = TW'($urandom_range(0, 5));
      end
   endtask

   // One job of n tiles. abort_at / rst_at: cycle to abort or reset in (-1 none).
   task automatic run_job(input int n, input int abort_at, input int rst_at,
                          input bit busy_starts, input bit check_totals);
      int te, nw, ns, nv, lat, ph, k, j;
      te  = t_end(n);
      nw  = 0;
      ns  = 0;
      nv  = 0;
      lat = -1;
      @(negedge clk);
      check_cycle("start", n, -1);
      quiet_inputs();
      start     = 1'b1;
      num_tiles = TW'(n);
      for (int c = 0; c <= te; c++) begin
         @(negedge clk);
         check_cycle("job", n, c);
         nw += (w_buffer_read === 1'b1) ? 1 : 0;
         ns += (sw === 1'b1) ? 1 : 0;
         nv += (of_valid === 1'b1) ? 1 : 0;
         if ((done === 1'b1) && (lat < 0)) lat = c + 1;
         if (c == rst_at) begin
            #2 rst = 1'b0;
            #1 check_reset("arst");
            #1 rst = 1'b1;
            quiet_inputs();
            return;
         end
         ph        = phase_of(n, c, k, j);
         start     = busy_starts && (c < te) && ($urandom_range(0, 3) == 0);
         num_tiles = TW'($urandom_range(0, 5));
         abort     = (c == abort_at);
         w_done    = ((ph == PH_PRE) && (j == SR - 1)) ||
                     ((ph == PH_STR) && (k < n - 1) && (j == SR - 1));
         if_done   = (ph == PH_STR) && (j == A - 1);
         if ((ph == PH_SWP) || (ph == PH_DRN) || (ph == PH_IDL)) begin
            w_done  = w_done  || ($urandom_range(0, 2) == 0);
            if_done = if_done || ($urandom_range(0, 2) == 0);
         end
         if (ph == PH_PRE) if_done = if_done || ($urandom_range(0, 2) == 0);
         if (c == abort_at) begin
            @(negedge clk);
            check_cycle("abort", n, -1);
            quiet_inputs();
            return;
         end
      end
      quiet_inputs();
      if (check_totals) begin
         chk("tot.w_read",   32'(nw),  32'(n * SR));
         chk("tot.switch",   32'(ns),  32'(n));
         chk("tot.of_valid", 32'(nv),  32'(n * A));
         chk("tot.latency",  32'(lat), 32'(1 + SR + n * (1 + A) + LAT));
      end
   endtask

   // start with num_tiles==0: done next cycle, nothing else moves.
   task automatic zero_job();
      @(negedge clk);
      check_cycle("zero.pre", 1, -1);
      quiet_inputs();
      start     = 1'b1;
      num_tiles = '0;
      @(negedge clk);
      chk("zero.done",   32'(done),          32'd1);
      chk("zero.busy",   32'(busy),          32'd0);
      chk("zero.w_read", 32'(w_buffer_read), 32'd0);
      chk("zero.ifread", 32'(if_buffer_read), 32'd0);
      chk("zero.switch", 32'(sw),            32'd0);
      quiet_inputs();
      @(negedge clk);
      check_cycle("zero.post", 1, -1);
   endtask

   // start together with abort must be dropped.
   task automatic start_abort(input int n);
      @(negedge clk);
      check_cycle("sa.pre", 1, -1);
      quiet_inputs();
      start     = 1'b1;
      abort     = 1'b1;
      num_tiles = TW'(n);
      @(negedge clk);
      check_cycle("sa.post", 1, -1);
      quiet_inputs();
   endtask

   initial begin
      int n, ab, te;
      rst       = 1'b0;
      num_tiles = '0;
      quiet_inputs();
      @(negedge clk);
      check_reset("reset");
      rst = 1'b1;
      idle(3);

      run_job(1, -1, -1, 1'b0, 1'b1);
      idle(2);
      run_job(3, -1, -1, 1'b0, 1'b1);
      idle(2);
      zero_job();
      idle(1);
      run_job(3, SR + (A + 1) + 1 + 3, -1, 1'b0, 1'b0);
      idle(2);
      run_job(2, -1, -1, 1'b0, 1'b1);
      idle(1);
      start_abort(2);
      start_abort(0);
      idle(1);
      run_job(2, -1, 2, 1'b0, 1'b0);
      idle(2);
      run_job(2, -1, -1, 1'b1, 1'b1);
      idle(2);

      for (int r = 0; r < 8; r++) begin
         n  = $urandom_range(1, 4);
         te = t_end(n);
         ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, te - 1) : -1;
         run_job(n, ab, -1, 1'($urandom_range(0, 1)), ab < 0);
         idle($urandom_range(1, 3));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
